// File: rtl/ddr3_clk_pkg.sv
// Shared types and defaults for the DDR3 clocking control block:
// phase-shift FSM state encoding and default hold/filter/timeout values.
package ddr3_clk_pkg;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_PULSE = 2'd1,
        PS_WAIT  = 2'd2,
        PS_DONE  = 2'd3
    } ps_state_t;

    localparam int DEF_RST_HOLD_CYCLES = 8;
    localparam int DEF_LOCK_FILTER     = 4;
    localparam int DEF_PS_TIMEOUT      = 64;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr3_rst_seq.sv
// MMCM lock synchroniser/filter and staged reset release; stage 0 releases first,
// each later stage RST_HOLD_CYCLES after the previous one.
module ddr3_rst_seq
    import ddr3_clk_pkg::*;
#(
    parameter int NUM_RST_OUT     = 3,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_FILTER     = DEF_LOCK_FILTER
) (
    input  logic                   clk_app,
    input  logic                   sys_rst,
    input  logic                   pll_lock,
    input  logic                   iodelay_ctrl_rdy,
    output logic                   lock_ok,
    output logic [NUM_RST_OUT-1:0] rst_out
);

    localparam int FILT_W = cnt_width(LOCK_FILTER);
    localparam int TOTAL  = RST_HOLD_CYCLES * NUM_RST_OUT;
    localparam int HOLD_W = cnt_width(TOTAL);

    logic              lock_meta;
    logic              lock_sync;
    logic [FILT_W-1:0] filt_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rst_cause;

    always_ff @(posedge clk_app) begin
        if (sys_rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            filt_cnt  <= '0;
            lock_ok   <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            // A single low sample drops qualification and restarts the filter.
            if (!lock_sync) begin
                filt_cnt <= '0;
                lock_ok  <= 1'b0;
            end else if (!lock_ok) begin
                filt_cnt <= filt_cnt + FILT_W'(1);
                if (filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
                    lock_ok <= 1'b1;
                end
            end
        end
    end

    assign rst_cause = sys_rst | ~lock_ok | ~iodelay_ctrl_rdy;

    // Monotonic thresholds on one counter guarantee in-order release.
    always_ff @(posedge clk_app) begin
        if (rst_cause) begin
            hold_cnt <= '0;
            rst_out  <= '1;
        end else begin
            if (hold_cnt != HOLD_W'(TOTAL)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            for (int i = 0; i < NUM_RST_OUT; i++) begin
                rst_out[i] <= (int'(hold_cnt) + 1) < (RST_HOLD_CYCLES * (i + 1));
            end
        end
    end

endmodule

// File: rtl/ddr3_clk_ps_rst_ctrl.sv
// DDR3 MMCM control companion in the PSCLK domain: staged resets plus a
// multi-step fine phase-shift engine with timeout and saturating position.
module ddr3_clk_ps_rst_ctrl
    import ddr3_clk_pkg::*;
#(
    parameter int NUM_RST_OUT     = 3,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_FILTER     = DEF_LOCK_FILTER,
    parameter int PS_STEP_W       = 10,
    parameter int PS_POS_W        = 12,
    parameter int PS_TIMEOUT      = DEF_PS_TIMEOUT
) (
    input  logic                       clk_app,
    input  logic                       sys_rst,
    input  logic                       pll_lock,
    input  logic                       iodelay_ctrl_rdy,
    output logic [NUM_RST_OUT-1:0]     rst_out,
    output logic                       lock_ok,
    input  logic                       ps_req_valid,
    output logic                       ps_req_ready,
    input  logic                       ps_req_dir,
    input  logic [PS_STEP_W-1:0]       ps_req_steps,
    output logic                       ps_busy,
    output logic                       ps_done,
    output logic                       ps_err,
    output logic signed [PS_POS_W-1:0] ps_pos,
    output logic                       PSEN,
    output logic                       PSINCDEC,
    input  logic                       PSDONE,
    output logic [1:0]                 ps_state
);

    // Handshake: a request transfers on a rising edge where ps_req_valid and
    // ps_req_ready are both high; ready is only offered in IDLE with lock qualified,
    // and the request fields are sampled on that same edge.

    localparam int TO_W = cnt_width(PS_TIMEOUT);
    localparam logic signed [PS_POS_W-1:0] POS_MAX = {1'b0, {(PS_POS_W-1){1'b1}}};
    localparam logic signed [PS_POS_W-1:0] POS_MIN = {1'b1, {(PS_POS_W-1){1'b0}}};
    localparam logic signed [PS_POS_W-1:0] POS_ONE = PS_POS_W'(1);

    ps_state_t            state;
    logic [PS_STEP_W-1:0] remaining;
    logic [TO_W-1:0]      to_cnt;

    ddr3_rst_seq #(
        .NUM_RST_OUT     (NUM_RST_OUT),
        .RST_HOLD_CYCLES (RST_HOLD_CYCLES),
        .LOCK_FILTER     (LOCK_FILTER)
    ) u_rst_seq (
        .clk_app          (clk_app),
        .sys_rst          (sys_rst),
        .pll_lock         (pll_lock),
        .iodelay_ctrl_rdy (iodelay_ctrl_rdy),
        .lock_ok          (lock_ok),
        .rst_out          (rst_out)
    );

    assign ps_req_ready = (state == PS_IDLE) && lock_ok;
    assign ps_busy      = (state != PS_IDLE);
    assign ps_state     = state;

    always_ff @(posedge clk_app) begin
        if (sys_rst) begin
            state     <= PS_IDLE;
            remaining <= '0;
            to_cnt    <= '0;
            ps_pos    <= '0;
            PSEN      <= 1'b0;
            PSINCDEC  <= 1'b0;
            ps_done   <= 1'b0;
            ps_err    <= 1'b0;
        end else if (!lock_ok) begin
            // A relocking MMCM forgets any applied shift, so the position restarts at zero.
            state   <= PS_IDLE;
            PSEN    <= 1'b0;
            ps_pos  <= '0;
            ps_done <= (state != PS_IDLE);
            if (state != PS_IDLE) begin
                ps_err <= 1'b1;
            end
        end else begin
            PSEN    <= 1'b0;
            ps_done <= 1'b0;
            case (state)
                PS_IDLE: begin
                    if (ps_req_valid) begin
                        ps_err    <= 1'b0;
                        PSINCDEC  <= ps_req_dir;
                        remaining <= ps_req_steps;
                        if (ps_req_steps == '0) begin
                            state   <= PS_DONE;
                            ps_done <= 1'b1;
                        end else begin
                            state <= PS_PULSE;
                            PSEN  <= 1'b1;
                        end
                    end
                end
                PS_PULSE: begin
                    state  <= PS_WAIT;
                    to_cnt <= '0;
                end
                PS_WAIT: begin
                    if (PSDONE) begin
                        remaining <= remaining - PS_STEP_W'(1);
                        // The MMCM already moved; only the tracked position clamps.
                        if (PSINCDEC) begin
                            if (ps_pos == POS_MAX) ps_err <= 1'b1;
                            else                   ps_pos <= ps_pos + POS_ONE;
                        end else begin
                            if (ps_pos == POS_MIN) ps_err <= 1'b1;
                            else                   ps_pos <= ps_pos - POS_ONE;
                        end
                        if (remaining == PS_STEP_W'(1)) begin
                            state   <= PS_DONE;
                            ps_done <= 1'b1;
                        end else begin
                            state <= PS_PULSE;
                            PSEN  <= 1'b1;
                        end
                    end else if (to_cnt == TO_W'(PS_TIMEOUT - 1)) begin
                        ps_err  <= 1'b1;
                        state   <= PS_DONE;
                        ps_done <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                PS_DONE: state <= PS_IDLE;
                default: state <= PS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_clk_ps_rst_ctrl.sv
// Bench for ddr3_clk_ps_rst_ctrl: directed scenarios plus randomized requests,
// an emulated MMCM responder and a cycle-level reference model.
module tb_ddr3_clk_ps_rst_ctrl;

    localparam int NRST   = 3;
    localparam int HOLD   = 8;
    localparam int LFILT  = 4;
    localparam int STEP_W = 10;
    localparam int POS_W  = 12;
    localparam int TMO    = 64;
    localparam int POS_MAX = (1 << (POS_W - 1)) - 1;
    localparam int POS_MIN = -(1 << (POS_W - 1));
    localparam int P_IDLE = 0, P_PULSE = 1, P_WAIT = 2, P_DONE = 3;

    // ---------------- clock / reset / DUT ----------------
    logic clk_app = 1'b0;
    always #5 clk_app = ~clk_app;

    logic               sys_rst = 1'b1;
    logic               pll_lock = 1'b0;
    logic               iodelay_ctrl_rdy = 1'b1;
    logic               ps_req_valid = 1'b0;
    logic               ps_req_dir = 1'b0;
    logic [STEP_W-1:0]  ps_req_steps = '0;
    logic               PSDONE = 1'b0;
    logic [NRST-1:0]    rst_out;
    logic               lock_ok, ps_req_ready, ps_busy, ps_done, ps_err, PSEN, PSINCDEC;
    logic signed [POS_W-1:0] ps_pos;
    logic [1:0]         ps_state;

    ddr3_clk_ps_rst_ctrl dut (
        .clk_app(clk_app), .sys_rst(sys_rst), .pll_lock(pll_lock),
        .iodelay_ctrl_rdy(iodelay_ctrl_rdy), .rst_out(rst_out), .lock_ok(lock_ok),
        .ps_req_valid(ps_req_valid), .ps_req_ready(ps_req_ready), .ps_req_dir(ps_req_dir),
        .ps_req_steps(ps_req_steps), .ps_busy(ps_busy), .ps_done(ps_done), .ps_err(ps_err),
        .ps_pos(ps_pos), .PSEN(PSEN), .PSINCDEC(PSINCDEC), .PSDONE(PSDONE), .ps_state(ps_state)
    );

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int psen_seen = 0;
    int done_seen = 0;
    int resp_mode = 2;   // 0 random delay, 1 withhold, 2 fixed 3, 3 fixed 1
    bit spurious_en = 1'b0;
    bit chaos_en = 1'b0;

    initial forever begin
        @(posedge clk_app);
        ecount++;
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // ---------------- reference model ----------------
    bit [15:0]     pl_hist = '0;
    bit [15:0]     rs_hist = '0;
    int            clean_run = 0;
    bit            m_lock = 1'b0;
    bit [NRST-1:0] m_rst = '1;
    bit            model_valid = 1'b0;
    int            phase = P_IDLE;
    int            left = 0;
    int            age = 0;
    int            m_pos = 0;
    bit            m_psen = 1'b0, m_incdec = 1'b0, m_done = 1'b0, m_err = 1'b0;

    task automatic model_step();
        bit lock_prev, cause, ok;
        int nxt;
        lock_prev = m_lock;
        pl_hist = {pl_hist[14:0], pll_lock};
        rs_hist = {rs_hist[14:0], sys_rst};
        // Qualified once the 2-cycle-delayed pll_lock has been high LFILT edges with no reset.
        ok = 1'b1;
        for (int k = 0; k <= LFILT + 1; k++) if (rs_hist[k]) ok = 1'b0;
        for (int k = 2; k <= LFILT + 1; k++) if (!pl_hist[k]) ok = 1'b0;
        m_lock = ok;
        cause = sys_rst || !lock_prev || !iodelay_ctrl_rdy;
        clean_run = cause ? 0 : ((clean_run < 100000) ? clean_run + 1 : clean_run);
        for (int i = 0; i < NRST; i++) m_rst[i] = (clean_run < HOLD * (i + 1));

        if (sys_rst) begin
            model_valid = 1'b1;
            phase = P_IDLE; left = 0; age = 0; m_pos = 0;
            m_psen = 0; m_incdec = 0; m_done = 0; m_err = 0;
        end else if (!lock_prev) begin
            m_done = (phase != P_IDLE);
            if (m_done) m_err = 1'b1;
            phase = P_IDLE; m_psen = 0; m_pos = 0;
        end else begin
            m_psen = 0;
            m_done = 0;
            case (phase)
                P_IDLE: if (ps_req_valid) begin
                    m_err = 0;
                    m_incdec = ps_req_dir;
                    left = int'(ps_req_steps);
                    if (left == 0) begin phase = P_DONE; m_done = 1; end
                    else begin phase = P_PULSE; m_psen = 1; end
                end
                P_PULSE: begin phase = P_WAIT; age = 0; end
                P_WAIT: if (PSDONE) begin
                    nxt = m_pos + (m_incdec ? 1 : -1);
                    if (nxt > POS_MAX || nxt < POS_MIN) m_err = 1;
                    else m_pos = nxt;
                    left--;
                    if (left == 0) begin phase = P_DONE; m_done = 1; end
                    else begin phase = P_PULSE; m_psen = 1; end
                end else begin
                    age++;
                    if (age >= TMO) begin m_err = 1; phase = P_DONE; m_done = 1; end
                end
                default: phase = P_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk_app);
        model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk_app);
        if (model_valid) begin
            chk("rst_out", rst_out, m_rst);
            chk("lock_ok", lock_ok, m_lock);
            chk("ps_req_ready", ps_req_ready, (phase == P_IDLE) && m_lock);
            chk("ps_busy", ps_busy, phase != P_IDLE);
            chk("ps_state_busy", ps_state != 2'd0, phase != P_IDLE);
            chk("ps_done", ps_done, m_done);
            chk("ps_err", ps_err, m_err);
            chk("ps_pos", ps_pos, m_pos);
            chk("PSEN", PSEN, m_psen);
            chk("PSINCDEC", PSINCDEC, m_incdec);
            if (PSEN) psen_seen++;
            if (ps_done) done_seen++;
        end
    end

    // ---------------- MMCM responder ----------------
    initial begin
        int pend;
        pend = 0;
        forever begin
            @(posedge clk_app);
            #1;
            PSDONE = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) PSDONE = 1'b1;
            end
            if (PSEN && resp_mode != 1)
                pend = (resp_mode == 2) ? 3 : (resp_mode == 3) ? 1 : $urandom_range(1, 4);
            if (spurious_en && !PSDONE && pend == 0 && $urandom_range(0, 30) == 0) PSDONE = 1'b1;
        end
    end

    // ---------------- disturbance process ----------------
    initial forever begin
        int r;
        @(posedge clk_app);
        #1;
        if (chaos_en) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk_app);
                #1 pll_lock = 1'b1;
            end else if (r < 6) begin
                iodelay_ctrl_rdy = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk_app);
                #1 iodelay_ctrl_rdy = 1'b1;
            end else if (r == 6) begin
                sys_rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(posedge clk_app);
                #1 sys_rst = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_app);
        #1;
    endtask

    task automatic do_req(input bit d, input int n);
        bit ok;
        ok = 1'b0;
        ps_req_dir = d;
        ps_req_steps = STEP_W'(n);
        ps_req_valid = 1'b1;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge clk_app);
            if (ps_req_ready) ok = 1'b1;
        end
        @(posedge clk_app);
        #1;
        ps_req_valid = 1'b0;
        chk("req_accepted", ok, 1);
    endtask

    task automatic wait_done(input int limit);
        bit found;
        found = 1'b0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clk_app);
            if (ps_done) found = 1'b1;
        end
        chk("done_seen", found, 1);
    endtask

    task automatic wait_idle(input int limit);
        bit found;
        found = 1'b0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clk_app);
            if (!ps_busy) found = 1'b1;
        end
        chk("idle_return", found, 1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete (edge %0d)", ecount);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int e0, lk, r0, r1, r2, g;
        step(4);
        sys_rst = 1'b0;
        step(3);

        // Reset release timing
        pll_lock = 1'b1;
        e0 = ecount;
        lk = -1; r0 = -1; r1 = -1; r2 = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk_app);
            if (lk < 0 && lock_ok) lk = ecount;
            if (r0 < 0 && !rst_out[0]) r0 = ecount;
            if (r1 < 0 && !rst_out[1]) r1 = ecount;
            if (r2 < 0 && !rst_out[2]) r2 = ecount;
        end
        chk("lock_latency", lk - e0, 6);
        chk("rst0_release", r0 - lk, 8);
        chk("rst1_release", r1 - lk, 16);
        chk("rst2_release", r2 - lk, 24);

        // Lock glitch during staging
        step(1);
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        lk = 0;
        for (int k = 0; k < 40 && lk == 0; k++) begin
            @(negedge clk_app);
            if (lock_ok) lk = 1;
        end
        chk("relock_seen", lk, 1);
        repeat (12) @(negedge clk_app);
        chk("mid_staging", rst_out, 3'b110);
        step(1);
        pll_lock = 1'b0;
        g = ecount + 1;
        step(1);
        pll_lock = 1'b1;
        repeat (4) @(negedge clk_app);
        chk("glitch_reassert", rst_out, 3'b111);
        r2 = -1;
        for (int k = 0; k < 60 && r2 < 0; k++) begin
            @(negedge clk_app);
            if (rst_out == '0) r2 = ecount;
        end
        chk("glitch_restart_release", r2 - g, 30);
        step(2);

        // Increment 5 with PSDONE 3 cycles after PSEN
        resp_mode = 2;
        psen_seen = 0; done_seen = 0;
        do_req(1'b1, 5);
        wait_done(200);
        step(3);
        chk("inc5_psen_count", psen_seen, 5);
        chk("inc5_done_count", done_seen, 1);
        chk("inc5_pos", ps_pos, 5);
        chk("inc5_err", ps_err, 0);

        // Timeout, then the next accept clears the error
        resp_mode = 1;
        psen_seen = 0;
        do_req(1'b1, 2);
        wait_done(300);
        step(2);
        chk("timeout_psen_count", psen_seen, 1);
        chk("timeout_err", ps_err, 1);
        chk("timeout_pos", ps_pos, 5);
        resp_mode = 2;
        do_req(1'b0, 1);
        @(negedge clk_app);
        chk("accept_clears_err", ps_err, 0);
        wait_done(200);
        step(1);
        chk("dec1_pos", ps_pos, 4);

        // Drive to positive limit, then overflow and zero-step requests
        resp_mode = 3;
        do_req(1'b1, 1023);
        wait_done(8000);
        step(1);
        do_req(1'b1, 1020);
        wait_done(8000);
        step(1);
        chk("at_max_pos", ps_pos, 2047);
        chk("at_max_err", ps_err, 0);
        psen_seen = 0;
        do_req(1'b1, 1);
        wait_done(200);
        step(1);
        chk("sat_psen_count", psen_seen, 1);
        chk("sat_pos", ps_pos, 2047);
        chk("sat_err", ps_err, 1);
        psen_seen = 0; done_seen = 0;
        do_req(1'b1, 0);
        @(negedge clk_app);
        chk("zero_done_next", ps_done, 1);
        step(4);
        chk("zero_psen_count", psen_seen, 0);
        chk("zero_done_count", done_seen, 1);
        chk("zero_err_cleared", ps_err, 0);

        // Lock loss while waiting for PSDONE
        resp_mode = 1;
        do_req(1'b0, 3);
        step(5);
        done_seen = 0;
        pll_lock = 1'b0;
        lk = 1;
        for (int k = 0; k < 10 && lk == 1; k++) begin
            @(negedge clk_app);
            if (!lock_ok) lk = 0;
        end
        chk("lock_dropped", lk, 0);
        @(negedge clk_app);
        chk("loss_busy", ps_busy, 0);
        chk("loss_done", ps_done, 1);
        chk("loss_err", ps_err, 1);
        chk("loss_pos", ps_pos, 0);
        chk("loss_ready", ps_req_ready, 0);
        step(10);
        chk("loss_done_count", done_seen, 1);
        pll_lock = 1'b1;
        lk = 0;
        for (int k = 0; k < 40 && lk == 0; k++) begin
            @(negedge clk_app);
            if (ps_req_ready) lk = 1;
        end
        chk("ready_after_relock", lk, 1);
        step(2);

        // Randomized requests with lock/iodelay/reset disturbances
        spurious_en = 1'b1;
        chaos_en = 1'b1;
        for (int t = 0; t < 150; t++) begin
            resp_mode = ($urandom_range(0, 14) == 0) ? 1 : 0;
            do_req(1'(($urandom_range(0, 1))), $urandom_range(0, 12));
            wait_idle(3000);
            step($urandom_range(0, 3));
        end
        chaos_en = 1'b0;
        spurious_en = 1'b0;
        step(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
